// File: rtl/itf_port_arbiter_if.sv
// Bundle of every signal between the DRAM port arbiter, its client engines
// and the pad ring. The master modport is the arbiter. The slave modport is
// the environment, which is the clients plus the pads.
//
// Handshake rule for every valid/ready pair on this bundle:
// - A beat transfers on a cycle where valid and ready are both high.
// - A source that has raised valid keeps valid and its data stable until that beat transfers.
// - Ready may be high or low whether or not valid is high.
interface itf_port_arbiter_if #(
  parameter int NUM_REQ         = 4,
  parameter int PORT_WIDTH      = 128,
  parameter int DRAM_ADDR_WIDTH = 32,
  parameter int ADDR_WIDTH      = 16
) ();
  logic [NUM_REQ-1:0]                 I_Req;
  logic [NUM_REQ-1:0]                 I_Dir;
  logic [NUM_REQ*DRAM_ADDR_WIDTH-1:0] I_Addr;
  logic [NUM_REQ*ADDR_WIDTH-1:0]      I_Num;
  logic [NUM_REQ-1:0]                 O_Gnt;
  logic [NUM_REQ-1:0]                 O_Done;
  logic [NUM_REQ*PORT_WIDTH-1:0]      I_WrDat;
  logic [NUM_REQ-1:0]                 I_WrVld;
  logic [NUM_REQ-1:0]                 O_WrRdy;
  logic [PORT_WIDTH-1:0]              O_RdDat;
  logic [NUM_REQ-1:0]                 O_RdVld;
  logic                               O_RdLast;
  logic [NUM_REQ-1:0]                 I_RdRdy;
  logic                               O_DatOE;
  logic [PORT_WIDTH-1:0]              O_Dat;
  logic                               O_DatVld;
  logic                               O_DatLast;
  logic                               I_DatRdy;
  logic [PORT_WIDTH-1:0]              I_Dat;
  logic                               I_DatVld;
  logic                               I_DatLast;
  logic                               O_DatRdy;
  logic                               O_LenErr;
  logic [2:0]                         DbgState;

  modport master (
    input  I_Req, I_Dir, I_Addr, I_Num, I_WrDat, I_WrVld, I_RdRdy,
    input  I_DatRdy, I_Dat, I_DatVld, I_DatLast,
    output O_Gnt, O_Done, O_WrRdy, O_RdDat, O_RdVld, O_RdLast,
    output O_DatOE, O_Dat, O_DatVld, O_DatLast, O_DatRdy, O_LenErr, DbgState
  );

  modport slave (
    output I_Req, I_Dir, I_Addr, I_Num, I_WrDat, I_WrVld, I_RdRdy,
    output I_DatRdy, I_Dat, I_DatVld, I_DatLast,
    input  O_Gnt, O_Done, O_WrRdy, O_RdDat, O_RdVld, O_RdLast,
    input  O_DatOE, O_Dat, O_DatVld, O_DatLast, O_DatRdy, O_LenErr, DbgState
  );
endinterface

// File: rtl/itf_port_arbiter.sv
// Round-robin owner of the single off-chip DRAM port.
// A grant carries one transaction: a command word, then a burst.
// For a write burst the chip drives the pads. For a read burst the DRAM drives them.
// The data path is combinational, so it adds no cycles of latency.
module itf_port_arbiter #(
  parameter int NUM_REQ         = 4,
  parameter int PORT_WIDTH      = 128,
  parameter int DRAM_ADDR_WIDTH = 32,
  parameter int ADDR_WIDTH      = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  itf_port_arbiter_if.master   bus
);
  localparam int IDXW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [2:0] {IDLE, CMD, IN, OUT, FNH} state_t;

  state_t                     state, stateNxt;
  logic [IDXW-1:0]            rrPtr, gntIdx, winIdx;
  logic                       winVld, winDir, dirQ, lenErr;
  logic [DRAM_ADDR_WIDTH-1:0] winAddr, addrQ;
  logic [ADDR_WIDTH-1:0]      winNum, numQ, cnt;
  logic [PORT_WIDTH-1:0]      selWrDat, cmdWord, dat, rdDat;
  logic                       selWrVld, selRdRdy, cntLast, outBeat, inBeat, inEnd;
  logic [NUM_REQ-1:0]         gntOh, done, wrRdy, rdVld;
  logic                       rdLast, datOE, datVld, datLast, datRdy;

  // Round-robin pick: first requester at or after the pointer, with wrap-around.
  always_comb begin
    int k;
    k      = 0;
    winVld = 1'b0;
    winIdx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      k = (int'(rrPtr) + i) % NUM_REQ;
      if (!winVld && bus.I_Req[k]) begin
        winVld = 1'b1;
        winIdx = IDXW'(k);
      end
    end
  end

  // Two selections from the packed client buses:
  // - the request fields of the arbitration winner;
  // - the data-path signals of the granted client.
  always_comb begin
    winDir   = 1'b0;
    winAddr  = '0;
    winNum   = '0;
    selWrDat = '0;
    selWrVld = 1'b0;
    selRdRdy = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (winIdx == IDXW'(k)) begin
        winDir  = bus.I_Dir[k];
        winAddr = bus.I_Addr[k*DRAM_ADDR_WIDTH +: DRAM_ADDR_WIDTH];
        winNum  = bus.I_Num[k*ADDR_WIDTH +: ADDR_WIDTH];
      end
      if (gntIdx == IDXW'(k)) begin
        selWrDat = bus.I_WrDat[k*PORT_WIDTH +: PORT_WIDTH];
        selWrVld = bus.I_WrVld[k];
        selRdRdy = bus.I_RdRdy[k];
      end
    end
  end

  // Beat bookkeeping. numQ is never zero in IN or OUT, so numQ-1 cannot underflow.
  assign cntLast = (cnt == ADDR_WIDTH'(numQ - 1'b1));
  assign outBeat = (state == OUT) && selWrVld && bus.I_DatRdy;
  assign inBeat  = (state == IN) && bus.I_DatVld && selRdRdy;
  assign inEnd   = inBeat && (bus.I_DatLast || cntLast);

  // Next-state logic for the transaction sequencer.
  always_comb begin
    stateNxt = state;
    case (state)
      IDLE:    if (winVld) stateNxt = (winNum == '0) ? FNH : CMD;
      CMD:     if (bus.I_DatRdy) stateNxt = dirQ ? OUT : IN;
      OUT:     if (outBeat && cntLast) stateNxt = FNH;
      IN:      if (inEnd) stateNxt = FNH;
      FNH:     stateNxt = IDLE;
      default: stateNxt = IDLE;
    endcase
  end

  // State register. Reset forces IDLE at once, which also drops any grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= stateNxt;
  end

  // Capture the winner's request once.
  // Later changes on the client side have no effect on the transaction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rrPtr  <= '0;
      gntIdx <= '0;
      dirQ   <= 1'b0;
      addrQ  <= '0;
      numQ   <= '0;
    end else if (state == IDLE && winVld) begin
      gntIdx <= winIdx;
      dirQ   <= winDir;
      addrQ  <= winAddr;
      numQ   <= winNum;
      rrPtr  <= (winIdx == IDXW'(NUM_REQ - 1)) ? '0 : winIdx + 1'b1;
    end
  end

  // Beat counter. It is cleared during the command phase.
  // It is as wide as Num, so the longest burst never wraps before its last beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 cnt <= '0;
    else if (state == CMD)      cnt <= '0;
    else if (outBeat || inBeat) cnt <= cnt + 1'b1;
  end

  // Sticky flag.
  // It sets when a read burst ends with DRAM-side last and the local count disagreeing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                     lenErr <= 1'b0;
    else if (inEnd && (bus.I_DatLast != cntLast))   lenErr <= 1'b1;
  end

  // Output steering. Every output idles at zero. OE is the exception: it stays high outside IN.
  always_comb begin
    gntOh   = (state != IDLE) ? (NUM_REQ'(1) << gntIdx) : '0;
    cmdWord = '0;
    cmdWord[0]                                         = dirQ;
    cmdWord[DRAM_ADDR_WIDTH:1]                         = addrQ;
    cmdWord[DRAM_ADDR_WIDTH+ADDR_WIDTH:DRAM_ADDR_WIDTH+1] = numQ;
    done    = '0;
    wrRdy   = '0;
    rdVld   = '0;
    rdDat   = '0;
    rdLast  = 1'b0;
    datOE   = 1'b1;
    dat     = '0;
    datVld  = 1'b0;
    datLast = 1'b0;
    datRdy  = 1'b0;
    case (state)
      CMD: begin
        dat    = cmdWord;
        datVld = 1'b1;
      end
      OUT: begin
        dat     = selWrDat;
        datVld  = selWrVld;
        datLast = selWrVld && cntLast;
        wrRdy   = bus.I_DatRdy ? gntOh : '0;
      end
      IN: begin
        datOE  = 1'b0;
        rdDat  = bus.I_Dat;
        rdVld  = bus.I_DatVld ? gntOh : '0;
        rdLast = bus.I_DatVld && (bus.I_DatLast || cntLast);
        datRdy = selRdRdy;
      end
      FNH:     done = gntOh;
      default: ;
    endcase
  end

  assign bus.O_Gnt     = gntOh;
  assign bus.O_Done    = done;
  assign bus.O_WrRdy   = wrRdy;
  assign bus.O_RdDat   = rdDat;
  assign bus.O_RdVld   = rdVld;
  assign bus.O_RdLast  = rdLast;
  assign bus.O_DatOE   = datOE;
  assign bus.O_Dat     = dat;
  assign bus.O_DatVld  = datVld;
  assign bus.O_DatLast = datLast;
  assign bus.O_DatRdy  = datRdy;
  assign bus.O_LenErr  = lenErr;
  assign bus.DbgState  = state;
endmodule

// File: tb/tb_itf_port_arbiter.sv
// Directed bench for itf_port_arbiter.
// Inputs change 1 time unit after the rising edge. Outputs are sampled 4 units after it.
module tb_itf_port_arbiter;
  localparam int NR = 4;
  localparam int PW = 128;
  localparam int AW = 32;
  localparam int LW = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;
  logic lenerr_exp = 1'b0;

  logic [PW-1:0] exp_q[$];
  logic [PW-1:0] dram [int];

  itf_port_arbiter_if #(.NUM_REQ(NR), .PORT_WIDTH(PW), .DRAM_ADDR_WIDTH(AW), .ADDR_WIDTH(LW)) bus ();

  itf_port_arbiter #(.NUM_REQ(NR), .PORT_WIDTH(PW), .DRAM_ADDR_WIDTH(AW), .ADDR_WIDTH(LW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [PW-1:0] got, input logic [PW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.I_Req = '0; bus.I_Dir = '0; bus.I_Addr = '0; bus.I_Num = '0;
    bus.I_WrDat = '0; bus.I_WrVld = '0; bus.I_RdRdy = '0;
    bus.I_DatRdy = 1'b0; bus.I_Dat = '0; bus.I_DatVld = 1'b0; bus.I_DatLast = 1'b0;
  endtask

  function automatic logic [PW-1:0] mk_cmd(input logic dir, input logic [31:0] a, input logic [15:0] n);
    mk_cmd = {79'd0, n, a, dir};
  endfunction

  // Common request + command phase; leaves the bench in the first data cycle.
  task automatic req_and_cmd(input int c, input logic dir, input logic [31:0] addr, input int num, input bit bp);
    logic [NR-1:0] oh;
    logic rdy;
    int budget;
    oh = NR'(1) << c;
    bus.I_Req[c] = 1'b1;
    bus.I_Dir[c] = dir;
    bus.I_Addr[c*AW +: AW] = addr;
    bus.I_Num[c*LW +: LW] = num[15:0];
    #3;
    check_eq("idle_gnt", bus.O_Gnt, '0);
    step();
    // Request withdrawn and address scrambled: the latched command must not change.
    bus.I_Req[c] = 1'b0;
    bus.I_Addr[c*AW +: AW] = ~addr;
    budget = 0;
    do begin
      rdy = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.I_DatRdy = rdy;
      #3;
      check_eq("cmd_gnt", bus.O_Gnt, oh);
      check_eq("cmd_vld", bus.O_DatVld, 1);
      check_eq("cmd_oe", bus.O_DatOE, 1);
      check_eq("cmd_word", bus.O_Dat, mk_cmd(dir, addr, num[15:0]));
      step();
      budget++;
    end while (!rdy && budget < 40);
    check_eq("cmd_accepted", rdy, 1);
  endtask

  task automatic finish_phase(input int c);
    logic [NR-1:0] oh;
    oh = NR'(1) << c;
    bus.I_WrVld = '0; bus.I_RdRdy = '0; bus.I_DatVld = 1'b0; bus.I_DatLast = 1'b0; bus.I_DatRdy = 1'b0;
    #3;
    check_eq("fnh_done", bus.O_Done, oh);
    check_eq("fnh_gnt", bus.O_Gnt, oh);
    check_eq("fnh_oe", bus.O_DatOE, 1);
    check_eq("fnh_datvld", bus.O_DatVld, 0);
    check_eq("fnh_lenerr", bus.O_LenErr, lenerr_exp);
    step();
    #3;
    check_eq("post_done", bus.O_Done, '0);
    check_eq("post_gnt", bus.O_Gnt, '0);
    step();
  endtask

  // Write burst: client c -> DRAM model; scoreboard compares model against presented data.
  task automatic run_out(input int c, input logic [31:0] addr, input int num, input bit bp);
    logic [NR-1:0] oh;
    logic vld, rdy, hold;
    logic [PW-1:0] wdat;
    int beat, budget;
    oh = NR'(1) << c;
    req_and_cmd(c, 1'b1, addr, num, bp);
    beat = 0; budget = 0; hold = 1'b0; vld = 1'b0; wdat = '0;
    while (beat < num && budget < 400) begin
      if (!hold) begin
        vld  = bp ? 1'($urandom_range(0, 1)) : 1'b1;
        wdat = {$urandom, $urandom, $urandom, $urandom};
      end
      rdy = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.I_WrVld[c] = vld;
      bus.I_WrDat[c*PW +: PW] = wdat;
      bus.I_DatRdy = rdy;
      #3;
      check_eq("out_oe", bus.O_DatOE, 1);
      check_eq("out_vld", bus.O_DatVld, vld);
      check_eq("out_wrrdy", bus.O_WrRdy, rdy ? oh : '0);
      check_eq("out_last", bus.O_DatLast, vld && (beat == num - 1));
      if (vld && rdy) begin
        dram[int'(addr) + beat] = bus.O_Dat;
        exp_q.push_back(wdat);
        beat++;
      end
      hold = vld && !rdy;
      step();
      budget++;
    end
    check_eq("out_beats", beat, num);
    finish_phase(c);
    for (int i = 0; i < num; i++) begin
      check_eq("out_dram", dram[int'(addr) + i], exp_q.pop_front());
    end
  endtask

  // Read burst: DRAM model -> client c; DRAM raises last on beat last_at.
  task automatic run_in(input int c, input logic [31:0] addr, input int num, input int last_at, input bit bp);
    logic [NR-1:0] oh;
    logic vld, rdy, hold, lst, ended;
    logic [PW-1:0] rdat;
    int beat, budget, nexp;
    oh = NR'(1) << c;
    nexp = (last_at < num) ? last_at : num;
    for (int i = 0; i < num; i++) dram[int'(addr) + i] = {$urandom, $urandom, $urandom, $urandom};
    for (int i = 0; i < nexp; i++) exp_q.push_back(dram[int'(addr) + i]);
    req_and_cmd(c, 1'b0, addr, num, bp);
    beat = 0; budget = 0; hold = 1'b0; vld = 1'b0; ended = 1'b0;
    while (!ended && budget < 400) begin
      if (!hold) vld = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      rdat = dram[int'(addr) + beat];
      lst  = (beat == last_at - 1);
      rdy  = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.I_Dat = rdat;
      bus.I_DatVld = vld;
      bus.I_DatLast = vld && lst;
      bus.I_RdRdy[c] = rdy;
      #3;
      check_eq("in_oe", bus.O_DatOE, 0);
      check_eq("in_rdvld", bus.O_RdVld, vld ? oh : '0);
      check_eq("in_datrdy", bus.O_DatRdy, rdy);
      check_eq("in_rdlast", bus.O_RdLast, vld && (lst || beat == num - 1));
      if (vld && rdy) begin
        check_eq("in_beat_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) check_eq("in_rddat", bus.O_RdDat, exp_q.pop_front());
        if (lst || beat == num - 1) begin
          ended = 1'b1;
          if (lst != (beat == num - 1)) lenerr_exp = 1'b1;
        end
        beat++;
      end
      hold = vld && !rdy;
      step();
      budget++;
    end
    check_eq("in_beats", beat, nexp);
    check_eq("in_q_empty", exp_q.size(), 0);
    finish_phase(c);
  endtask

  initial begin
    int order[$];
    int exp_order[5];
    int budget;
    exp_order = '{0, 1, 2, 3, 0};
    clear_inputs();

    // 1. Reset held 10 cycles
    rst_n = 1'b0;
    repeat (10) step();
    #3;
    check_eq("rst_oe", bus.O_DatOE, 1);
    check_eq("rst_gnt", bus.O_Gnt, '0);
    check_eq("rst_datvld", bus.O_DatVld, 0);
    check_eq("rst_datrdy", bus.O_DatRdy, 0);
    check_eq("rst_lenerr", bus.O_LenErr, 0);
    check_eq("rst_state", bus.DbgState, 0);
    step();
    rst_n = 1'b1;
    step();

    // 2. Client0 write, Addr 0x100, Num 4, DRAM always ready
    run_out(0, 32'h100, 4, 1'b0);
    // 3. Client2 read, Addr 0x40, Num 3, last on beat 3
    run_in(2, 32'h40, 3, 3, 1'b0);
    // 5. Backpressure on both directions, Num 8
    run_out(1, 32'h300, 8, 1'b1);
    run_in(3, 32'h500, 8, 8, 1'b1);
    // Num = 1: first beat is last
    run_out(2, 32'h700, 1, 1'b0);

    // 6a. Num = 0: straight to FNH, no command beat
    bus.I_Req[1] = 1'b1; bus.I_Dir[1] = 1'b1; bus.I_Num[1*LW +: LW] = '0;
    #3;
    check_eq("num0_idle_vld", bus.O_DatVld, 0);
    step();
    bus.I_Req[1] = 1'b0;
    finish_phase(1);

    // 6b. Read with early DRAM last on beat 2 of 5
    run_in(0, 32'h80, 5, 2, 1'b0);
    check_eq("lenerr_set", bus.O_LenErr, 1);

    // 6c. Reset mid write burst
    req_and_cmd(1, 1'b1, 32'h200, 8, 1'b0);
    bus.I_WrVld[1] = 1'b1; bus.I_DatRdy = 1'b1;
    step();
    step();
    rst_n = 1'b0;
    #3;
    check_eq("arst_gnt", bus.O_Gnt, '0);
    check_eq("arst_oe", bus.O_DatOE, 1);
    check_eq("arst_datvld", bus.O_DatVld, 0);
    check_eq("arst_wrrdy", bus.O_WrRdy, '0);
    check_eq("arst_done", bus.O_Done, '0);
    step();
    #3;
    check_eq("arst_done_next", bus.O_Done, '0);
    check_eq("arst_lenerr", bus.O_LenErr, 0);
    lenerr_exp = 1'b0;
    step();
    clear_inputs();
    rst_n = 1'b1;
    step();

    // 4. All four request continuously with Num 1: fair rotation from pointer 0
    bus.I_Req = '1; bus.I_Dir = '1; bus.I_WrVld = '1; bus.I_DatRdy = 1'b1;
    for (int k = 0; k < NR; k++) bus.I_Num[k*LW +: LW] = 16'd1;
    budget = 0;
    while (order.size() < 5 && budget < 80) begin
      #3;
      for (int k = 0; k < NR; k++) if (bus.O_Done[k]) order.push_back(k);
      if (order.size() == 5) bus.I_Req = '0;
      step();
      budget++;
    end
    check_eq("rr_count", order.size(), 5);
    for (int i = 0; i < 5; i++) begin
      if (i < order.size()) check_eq("rr_order", order[i], exp_order[i]);
    end
    clear_inputs();
    step();
    #3;
    check_eq("rr_idle_gnt", bus.O_Gnt, '0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
